// File: rtl/tia_hsync_counter.sv
// TIA horizontal sync counter: colour-clock prescaler feeding a 6-bit XNOR LFSR,
// with registered active-low strobes decoded from fixed LFSR states.
module tia_hsync_counter #(
   parameter int LINE_STEPS = 57,
   parameter int DIV        = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rsync,
   input  logic       hmove_latch,
   output logic [5:0] h_state,
   output logic       phi1,
   output logic       phi2,
   output logic       shb_n,
   output logic       shs_n,
   output logic       rhs_n,
   output logic       rcb_n,
   output logic       rhb_n,
   output logic       end_n
);

   localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

   function automatic logic [5:0] lfsr_next(input logic [5:0] s);
      return {s[4:0], ~(s[5] ^ s[4])};
   endfunction

   // State reached after n advances from 000000; evaluated at elaboration only.
   function automatic logic [5:0] lfsr_pat(input int n);
      logic [5:0] s;
      s = 6'b000000;
      for (int i = 0; i < 63; i++) begin
         if (i < n) begin
            s = lfsr_next(s);
         end else begin
            s = s;
         end
      end
      return s;
   endfunction

   localparam logic [5:0] PAT_LAST     = lfsr_pat(LINE_STEPS - 1);
   localparam logic [5:0] PAT_SHS      = lfsr_pat(4);
   localparam logic [5:0] PAT_RHS      = lfsr_pat(8);
   localparam logic [5:0] PAT_RCB      = lfsr_pat(12);
   localparam logic [5:0] PAT_RHB      = lfsr_pat(16);
   localparam logic [5:0] PAT_RHB_LATE = lfsr_pat(18);
   localparam logic [5:0] PAT_SHB      = lfsr_pat(56);

   logic [PW-1:0] p_r;
   logic [5:0]    lfsr_r;
   logic          hm_r;
   logic          shb_r, shs_r, rhs_r, rcb_r, rhb_r, end_r;

   logic          adv_s;
   logic [5:0]    lfsr_nx_s;
   logic          hm_nx_s;
   logic          shb_nx_s, shs_nx_s, rhs_nx_s, rcb_nx_s, rhb_nx_s, end_nx_s;

   // Next LFSR state, hmove sample and strobe levels for the step about to be entered.
   always_comb begin
      adv_s     = (p_r == PW'(DIV - 1));
      lfsr_nx_s = 6'b000000;
      hm_nx_s   = hm_r;
      if (lfsr_r == PAT_LAST) begin
         lfsr_nx_s = 6'b000000;
      end else begin
         lfsr_nx_s = lfsr_next(lfsr_r);
      end
      if (lfsr_nx_s == PAT_RHB) begin
         hm_nx_s = hmove_latch;
      end else begin
         hm_nx_s = hm_r;
      end
      shs_nx_s = (lfsr_nx_s != PAT_SHS);
      rhs_nx_s = (lfsr_nx_s != PAT_RHS);
      rcb_nx_s = (lfsr_nx_s != PAT_RCB);
      shb_nx_s = (lfsr_nx_s != PAT_SHB);
      end_nx_s = (lfsr_nx_s != PAT_SHB);
      rhb_nx_s = ~(((lfsr_nx_s == PAT_RHB) && !hmove_latch) ||
                   ((lfsr_nx_s == PAT_RHB_LATE) && hm_r));
   end

   // Prescaler; rsync holds it at 0.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         p_r <= PW'(0);
      end else if (rsync) begin
         p_r <= PW'(0);
      end else if (p_r == PW'(DIV - 1)) begin
         p_r <= PW'(0);
      end else begin
         p_r <= p_r + PW'(1);
      end
   end

   // LFSR, hmove sample and strobes move together so strobes track h_state exactly.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lfsr_r <= 6'b000000;
         hm_r   <= 1'b0;
         shb_r  <= 1'b1;
         shs_r  <= 1'b1;
         rhs_r  <= 1'b1;
         rcb_r  <= 1'b1;
         rhb_r  <= 1'b1;
         end_r  <= 1'b1;
      end else if (rsync) begin
         lfsr_r <= 6'b000000;
         hm_r   <= hm_r;
         shb_r  <= 1'b1;
         shs_r  <= 1'b1;
         rhs_r  <= 1'b1;
         rcb_r  <= 1'b1;
         rhb_r  <= 1'b1;
         end_r  <= 1'b1;
      end else if (adv_s) begin
         lfsr_r <= lfsr_nx_s;
         hm_r   <= hm_nx_s;
         shb_r  <= shb_nx_s;
         shs_r  <= shs_nx_s;
         rhs_r  <= rhs_nx_s;
         rcb_r  <= rcb_nx_s;
         rhb_r  <= rhb_nx_s;
         end_r  <= end_nx_s;
      end else begin
         lfsr_r <= lfsr_r;
         hm_r   <= hm_r;
         shb_r  <= shb_r;
         shs_r  <= shs_r;
         rhs_r  <= rhs_r;
         rcb_r  <= rcb_r;
         rhb_r  <= rhb_r;
         end_r  <= end_r;
      end
   end

   assign h_state = lfsr_r;
   assign phi1    = (p_r == PW'(0));
   assign phi2    = (p_r == PW'(DIV / 2));
   assign shb_n   = shb_r;
   assign shs_n   = shs_r;
   assign rhs_n   = rhs_r;
   assign rcb_n   = rcb_r;
   assign rhb_n   = rhb_r;
   assign end_n   = end_r;

endmodule

// File: tb/tb_tia_hsync_counter.sv
// Bench for tia_hsync_counter: cycle-count reference model compared every clock,
// plus directed checks at hand-computed clock numbers.
module tb_tia_hsync_counter;

   localparam int DIV      = 4;
   localparam int LS       = 57;
   localparam int LINE_CLK = DIV * LS;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rsync = 1'b0;
   logic       hmove_latch = 1'b0;
   logic [5:0] h_state;
   logic       phi1, phi2, shb_n, shs_n, rhs_n, rcb_n, rhb_n, end_n;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   edge_no = 0;
   bit   chk_en = 1'b0;

   int         cnt_m = 0;
   logic       hm_m = 1'b0;
   logic [5:0] pat_m [0:62];

   tia_hsync_counter #(.LINE_STEPS(LS), .DIV(DIV)) dut (
      .clock(clock), .reset(reset), .rsync(rsync), .hmove_latch(hmove_latch),
      .h_state(h_state), .phi1(phi1), .phi2(phi2), .shb_n(shb_n), .shs_n(shs_n),
      .rhs_n(rhs_n), .rcb_n(rcb_n), .rhb_n(rhb_n), .end_n(end_n)
   );

   always #5 clock = ~clock;

   initial begin
      pat_m[0] = 6'b000000;
      for (int i = 1; i < 63; i++)
         pat_m[i] = {pat_m[i-1][4:0], ~(pat_m[i-1][5] ^ pat_m[i-1][4])};
   end

   // Model state: colour clocks since reset/rsync, plus the hmove level seen entering step 16.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_m <= 0;
      end else if (rsync) begin
         cnt_m <= 0;
      end else begin
         cnt_m <= cnt_m + 1;
         if (((cnt_m + 1) % LINE_CLK) == 16 * DIV) hm_m <= hmove_latch;
      end
   end

   function automatic logic [13:0] model_out(input int cnt, input logic hm);
      int c, step, p;
      c    = cnt % LINE_CLK;
      step = c / DIV;
      p    = c % DIV;
      return {pat_m[step], (p == 0), (p == DIV / 2),
              !(step == 56), !(step == 4), !(step == 8), !(step == 12),
              !((step == 16 && !hm) || (step == 18 && hm)), !(step == 56)};
   endfunction

   wire [13:0] dut_out = {h_state, phi1, phi2, shb_n, shs_n, rhs_n, rcb_n, rhb_n, end_n};

   always @(negedge clock) begin
      if (chk_en) begin
         n_cmp++;
         if (dut_out !== model_out(cnt_m, hm_m)) begin
            n_bad++;
            $display("FAIL model_cmp t=%0t dut=%b model=%b", $time, dut_out, model_out(cnt_m, hm_m));
         end
      end
   end

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic goto(input int n);
      while (edge_no < n) begin
         @(posedge clock);
         edge_no++;
      end
      #1;
   endtask

   task automatic release_reset();
      @(negedge clock);
      #1 reset = 1'b1;
      edge_no = 0;
   endtask

   task automatic timing_line_start(input string tag);
      goto(4);   check({tag, "_h4"},     {10'd0, h_state}, 16'h0001);
      goto(15);  check({tag, "_shs15"},  {15'd0, shs_n}, 16'h0001);
      goto(16);  check({tag, "_shs16"},  {15'd0, shs_n}, 16'h0000);
      goto(19);  check({tag, "_shs19"},  {15'd0, shs_n}, 16'h0000);
      goto(20);  check({tag, "_shs20"},  {15'd0, shs_n}, 16'h0001);
      goto(32);  check({tag, "_rhs32"},  {15'd0, rhs_n}, 16'h0000);
      goto(36);  check({tag, "_rhs36"},  {15'd0, rhs_n}, 16'h0001);
      goto(48);  check({tag, "_rcb48"},  {15'd0, rcb_n}, 16'h0000);
      goto(51);  check({tag, "_rcb51"},  {15'd0, rcb_n}, 16'h0000);
   endtask

   logic [5:0] states [0:56];
   int dup, ones, base;

   initial begin
      #1 reset = 1'b0;
      @(negedge clock);
      @(negedge clock);
      #1;
      check("rst_h",   {10'd0, h_state}, 16'h0000);
      check("rst_out", {8'd0, phi1, phi2, shb_n, shs_n, rhs_n, rcb_n, rhb_n, end_n}, 16'h00BF);
      chk_en = 1'b1;

      // Line 1 timing after release
      release_reset();
      timing_line_start("t1");
      goto(64);  check("t2_rhb64",  {15'd0, rhb_n}, 16'h0000);
      goto(67);  check("t2_rhb67",  {15'd0, rhb_n}, 16'h0000);
      goto(68);  check("t2_rhb68",  {15'd0, rhb_n}, 16'h0001);
      goto(224); check("t2_shb224", {14'd0, shb_n, end_n}, 16'h0000);
      goto(227); check("t2_shb227", {14'd0, shb_n, end_n}, 16'h0000);
      goto(228); check("t2_wrap",   {8'd0, h_state, shb_n, end_n}, 16'h0003);

      // Line 2: every step state distinct, never all-ones
      for (int k = 0; k < LS; k++) begin
         goto(228 + 4 * k);
         states[k] = h_state;
      end
      dup = 0; ones = 0;
      for (int a = 0; a < LS; a++) begin
         if (states[a] == 6'b111111) ones++;
         for (int b = a + 1; b < LS; b++)
            if (states[a] == states[b]) dup++;
      end
      check("t6_dups", dup[15:0], 16'h0000);
      check("t6_ones", ones[15:0], 16'h0000);
      goto(456); check("t6_period", {10'd0, h_state}, 16'h0000);

      // Line 3: late HBLANK end, toggle during step 17 ignored
      goto(460); hmove_latch = 1'b1;
      goto(456 + 64); check("t3_rhb64", {15'd0, rhb_n}, 16'h0001);
      goto(456 + 67); check("t3_rhb67", {15'd0, rhb_n}, 16'h0001);
      goto(456 + 69); hmove_latch = 1'b0;
      goto(456 + 72); check("t3_rhb72", {15'd0, rhb_n}, 16'h0000);
      goto(456 + 75); check("t3_rhb75", {15'd0, rhb_n}, 16'h0000);
      goto(456 + 76); check("t3_rhb76", {15'd0, rhb_n}, 16'h0001);

      // Line 4: single-clock rsync at clock 100, then held rsync
      goto(912 + 99);  rsync = 1'b1;
      goto(912 + 100); rsync = 1'b0;
      check("t4_sync", {2'd0, h_state, phi1, phi2, shb_n, shs_n, rhs_n, rcb_n, rhb_n, end_n}, 16'h00BF);
      goto(1012 + 15); check("t4_shs15", {15'd0, shs_n}, 16'h0001);
      goto(1012 + 16); check("t4_shs16", {15'd0, shs_n}, 16'h0000);
      goto(1040); rsync = 1'b1;
      goto(1043); rsync = 1'b0;
      check("t4_hold", {8'd0, h_state, phi1, phi2}, 16'h0002);
      base = 1043;

      // Async reset mid-step 5, away from any edge
      goto(base + 21);
      #2 reset = 1'b0;
      #1;
      check("t5_rst", {2'd0, h_state, phi1, phi2, shb_n, shs_n, rhs_n, rcb_n, rhb_n, end_n}, 16'h00BF);
      release_reset();
      timing_line_start("t5");
      goto(64);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
